// File: rtl/tt_ovi_pkg.sv
// Shared types and widths for the OVI issue path: entry state, buffered
// issue entry, and the sideband widths used by the issue buffer and sb_id FIFO.
package tt_ovi_pkg;

    localparam int SB_ID_W  = 5;
    localparam int VCSR_W   = 41;
    localparam int INST_W   = 32;
    localparam int OPND_W   = 64;
    localparam int FFLAGS_W = 5;

    typedef enum logic [1:0] {
        PEND   = 2'd0,
        SENIOR = 2'd1,
        KILLED = 2'd2
    } entry_state_e;

    typedef struct packed {
        entry_state_e        state;
        logic [SB_ID_W-1:0]  sb_id;
        logic [INST_W-1:0]   inst;
        logic [OPND_W-1:0]   scalar_opnd;
        logic [VCSR_W-1:0]   vcsr;
    } issue_entry_t;

    // The pipeline sees lmulb2 as the top bit of the vcsr word.
    function automatic logic [VCSR_W-1:0] pack_vcsr(input logic                lmulb2,
                                                    input logic [VCSR_W-2:0]   vcsr);
        return {lmulb2, vcsr};
    endfunction

endpackage

// File: rtl/tt_ovi_sbid_fifo.sv
// In-order FIFO of sb_ids for instructions handed to the vector pipeline;
// the head is the next instruction expected to commit.
module tt_ovi_sbid_fifo
    import tt_ovi_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_push,
    input  logic [SB_ID_W-1:0] i_push_id,
    input  logic               i_pop,
    output logic [SB_ID_W-1:0] o_head_id,
    output logic [CNT_W-1:0]   o_count
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [SB_ID_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic               w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop on empty is ignored; a push into a full FIFO only lands alongside a pop.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != DEPTH_C) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_head_id = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/tt_ovi_issue_ctrl.sv
// OVI issue controller: buffers issued instructions, resolves dispatch
// (senior/kill), feeds the vector pipeline in order and reports completions.
module tt_ovi_issue_ctrl
    import tt_ovi_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                issue_valid,
    input  logic [INST_W-1:0]   issue_inst,
    input  logic [SB_ID_W-1:0]  issue_sb_id,
    input  logic [OPND_W-1:0]   issue_scalar_opnd,
    input  logic [VCSR_W-2:0]   issue_vcsr,
    input  logic                issue_vcsr_lmulb2,
    output logic                issue_credit,
    input  logic [SB_ID_W-1:0]  dispatch_sb_id,
    input  logic                dispatch_next_senior,
    input  logic                dispatch_kill,
    output logic                pipe_valid,
    input  logic                pipe_ready,
    output logic [INST_W-1:0]   pipe_inst,
    output logic [OPND_W-1:0]   pipe_scalar_opnd,
    output logic [VCSR_W-1:0]   pipe_vcsr,
    input  logic                pipe_commit_valid,
    input  logic [FFLAGS_W-1:0] pipe_commit_fflags,
    output logic                completed_valid,
    output logic [SB_ID_W-1:0]  completed_sb_id,
    output logic [FFLAGS_W-1:0] completed_fflags,
    output logic                err
);

    localparam int                  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  CNT_W    = $clog2(DEPTH + 1);
    localparam int                  IF_CNT_W = $clog2(INFLIGHT + 1);
    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [IF_CNT_W-1:0] IF_C     = IF_CNT_W'(INFLIGHT);

    issue_entry_t           r_buf [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err;
    logic                   r_credit;
    logic                   r_cmp_valid;
    logic [SB_ID_W-1:0]     r_cmp_id;
    logic [FFLAGS_W-1:0]    r_cmp_fflags;

    issue_entry_t           w_head_ent;
    issue_entry_t           w_new_ent;
    logic                   w_buf_nonempty;
    logic                   w_head_senior;
    logic                   w_head_killed;
    logic                   w_pipe_valid;
    logic                   w_xfer;
    logic                   w_pop;
    logic                   w_issue_acc;
    logic                   w_issue_drop;
    logic                   w_pend_found;
    logic [PTR_W-1:0]       w_pend_idx;
    logic                   w_disp;
    logic                   w_match;
    logic                   w_disp_err;
    logic [SB_ID_W-1:0]     w_if_head_id;
    logic [IF_CNT_W-1:0]    w_if_count;
    logic                   w_commit_ok;
    logic                   w_commit_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_head_ent     = r_buf[r_head];
    assign w_buf_nonempty = (r_count != '0);
    assign w_head_senior  = w_buf_nonempty && (w_head_ent.state == SENIOR);
    assign w_head_killed  = w_buf_nonempty && (w_head_ent.state == KILLED);
    assign w_pipe_valid   = w_head_senior && (w_if_count < IF_C);
    assign w_xfer         = w_pipe_valid && pipe_ready;
    assign w_pop          = w_xfer || w_head_killed;

    // Full is judged on the registered count, so a same-cycle pop cannot make room.
    assign w_issue_acc  = issue_valid && (r_count != DEPTH_C);
    assign w_issue_drop = issue_valid && (r_count == DEPTH_C);

    assign w_new_ent = '{state:       PEND,
                         sb_id:       issue_sb_id,
                         inst:        issue_inst,
                         scalar_opnd: issue_scalar_opnd,
                         vcsr:        pack_vcsr(issue_vcsr_lmulb2, issue_vcsr)};

    // Oldest PEND entry among those present at the start of the cycle.
    always_comb begin
        logic [PTR_W:0] v_sum;
        w_pend_found = 1'b0;
        w_pend_idx   = '0;
        v_sum        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_sum = {1'b0, r_head} + (PTR_W + 1)'(i);
            if (v_sum >= (PTR_W + 1)'(DEPTH)) begin
                v_sum = v_sum - (PTR_W + 1)'(DEPTH);
            end
            if (!w_pend_found && (i < int'(r_count)) &&
                (r_buf[v_sum[PTR_W-1:0]].state == PEND)) begin
                w_pend_found = 1'b1;
                w_pend_idx   = v_sum[PTR_W-1:0];
            end
        end
    end

    assign w_disp     = dispatch_next_senior || dispatch_kill;
    assign w_match    = w_pend_found && (r_buf[w_pend_idx].sb_id == dispatch_sb_id);
    assign w_disp_err = (w_disp && !w_match) || (dispatch_next_senior && dispatch_kill);

    assign w_commit_ok  = pipe_commit_valid && (w_if_count != '0);
    assign w_commit_err = pipe_commit_valid && (w_if_count == '0);

    tt_ovi_sbid_fifo #(
        .DEPTH (INFLIGHT),
        .CNT_W (IF_CNT_W)
    ) u_sbid_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_xfer),
        .i_push_id (w_head_ent.sb_id),
        .i_pop     (pipe_commit_valid),
        .o_head_id (w_if_head_id),
        .o_count   (w_if_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_credit     <= 1'b0;
            r_cmp_valid  <= 1'b0;
            r_cmp_id     <= '0;
            r_cmp_fflags <= '0;
        end else begin
            // Dispatch targets a PEND entry, so it never collides with the popped head
            // or with the tail slot being written.
            if (w_disp && w_match) begin
                r_buf[w_pend_idx].state <= dispatch_kill ? KILLED : SENIOR;
            end
            if (w_issue_acc) begin
                r_buf[r_tail] <= w_new_ent;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            r_count     <= r_count + CNT_W'(w_issue_acc) - CNT_W'(w_pop);
            r_err       <= r_err | w_issue_drop | w_disp_err | w_commit_err;
            r_credit    <= w_pop;
            r_cmp_valid <= w_commit_ok;
            if (w_commit_ok) begin
                r_cmp_id     <= w_if_head_id;
                r_cmp_fflags <= pipe_commit_fflags;
            end
        end
    end

    assign issue_credit     = r_credit;
    assign pipe_valid       = w_pipe_valid;
    assign pipe_inst        = w_head_ent.inst;
    assign pipe_scalar_opnd = w_head_ent.scalar_opnd;
    assign pipe_vcsr        = w_head_ent.vcsr;
    assign completed_valid  = r_cmp_valid;
    assign completed_sb_id  = r_cmp_id;
    assign completed_fflags = r_cmp_fflags;
    assign err              = r_err;

endmodule
